// File: rtl/mdu_pkg.sv
// Shared encodings and elaboration helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  localparam int MDU_MAX_UNROLL = 4;

  function automatic bit mdu_unroll_legal(input int w, input int u);
    return ((u == 1) || (u == 2) || (u == MDU_MAX_UNROLL)) && ((w % u) == 0);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division bit: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, shift the result bit into the quotient.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // rem < div always holds, so the shifted value fits in WIDTH+1 bits and
  // the top bit of the difference is a clean borrow flag.
  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign w_fits  = ~w_diff[WIDTH];

  assign o_rem  = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quot = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// Magnitudes are computed unsigned over WIDTH/UNROLL cycles, signs applied in FIX.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = $clog2(N + 1);

  if (!mdu_unroll_legal(WIDTH, UNROLL)) begin : g_bad_unroll
    $error("muldiv_unit: UNROLL must be 1, 2 or 4 and divide WIDTH");
  end

  mdu_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_rem;   // product high half or partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier/product low half or dividend/quotient
  logic             r_sa, r_sb, r_div, r_dz;
  logic             r_done;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_accept, w_muldiv, w_signed, w_isdiv, w_dz;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_accept = start & ~flush & (r_state == IDLE);
  assign w_muldiv = ~op[2];
  assign w_isdiv  = (op == MDU_DIV) || (op == MDU_DIVU);
  assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign w_dz     = w_isdiv && (in2 == '0);
  assign w_a_abs  = (w_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign w_b_abs  = (w_signed && in2[WIDTH-1]) ? -in2 : in2;

  // Per-iteration chains: stage 0 is the register contents.
  logic [UNROLL:0][WIDTH-1:0] w_mrem, w_mq, w_drem, w_dq;

  assign w_mrem[0] = r_rem;
  assign w_mq[0]   = r_q;
  assign w_drem[0] = r_rem;
  assign w_dq[0]   = r_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    logic [WIDTH:0] w_sum;
    assign w_sum        = {1'b0, w_mrem[i]} + (w_mq[i][0] ? {1'b0, r_d} : '0);
    assign w_mrem[i+1]  = w_sum[WIDTH:1];
    assign w_mq[i+1]    = {w_sum[0], w_mq[i][WIDTH-1:1]};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem  (w_drem[i]),
      .i_quot (w_dq[i]),
      .i_div  (r_d),
      .o_rem  (w_drem[i+1]),
      .o_quot (w_dq[i+1])
    );
  end

  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_hi_fix, w_lo_fix;

  assign w_prod     = {r_rem, r_q};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;

  always_comb begin
    w_hi_fix = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod_fix[WIDTH-1:0];
    if (r_dz) begin
      w_hi_fix = r_rem;
      w_lo_fix = r_q;
    end else if (r_div) begin
      w_hi_fix = r_sa ? -r_rem : r_rem;
      w_lo_fix = (r_sa ^ r_sb) ? -r_q : r_q;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_muldiv) w_state_nxt = w_dz ? FIX : CALC;
      CALC:    if (r_cnt == CW'(1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_d    <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_div  <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= (r_state == FIX) && !flush;
      case (r_state)
        IDLE: begin
          if (w_accept && w_muldiv) begin
            r_cnt <= CW'(N);
            r_sa  <= w_signed & in1[WIDTH-1];
            r_sb  <= w_signed & in2[WIDTH-1];
            r_div <= w_isdiv;
            r_dz  <= w_dz;
            r_d   <= w_isdiv ? w_b_abs : w_a_abs;
            r_rem <= w_dz ? in1 : '0;
            r_q   <= w_dz ? '1 : (w_isdiv ? w_a_abs : w_b_abs);
          end else if (w_accept && op == MDU_MTHI) begin
            r_hi <= in1;
          end else if (w_accept && op == MDU_MTLO) begin
            r_lo <= in1;
          end
        end
        CALC: begin
          r_cnt <= r_cnt - CW'(1);
          r_rem <= r_div ? w_drem[UNROLL] : w_mrem[UNROLL];
          r_q   <= r_div ? w_dq[UNROLL]   : w_mq[UNROLL];
        end
        FIX: begin
          if (!flush) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
